mem_access_unit: RTL and testbench

Sequencing unit between the core's load/store outputs and the word-organised synchronous data memory. Accepts one byte or word load/store request at a time. Converts byte addresses to word addresses and performs read-modify-write for byte stores. Returns aligned, optionally sign-extended load data with a one-cycle `ready` pulse.

---
 rtl/mem_access_unit.sv | 157 +++++++++++++++
 tb/tb_mem_access_unit.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - byte/word load-store sequencer for a word-organised synchronous data memory
// Optional misaligned-word trap (and the fault_o port) enabled by defining MAU_MISALIGN_TRAP_EN.
module mem_access_unit #(
   parameter int ADDR_W = 16,
   parameter int RD_LAT = 1
) (
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic              req_rd_i,
   input  logic              req_wr_i,
   input  logic              byte_op_i,
   input  logic              sext_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [15:0]       wdata_i,
   output logic [15:0]       rdata_o,
   output logic              ready_o,
   output logic              busy_o,
`ifdef MAU_MISALIGN_TRAP_EN
   output logic              fault_o,
`endif
   output logic [ADDR_W-2:0] mem_addr_o,
   output logic              mem_re_o,
   output logic              mem_we_o,
   output logic [15:0]       mem_wdata_o,
   input  logic [15:0]       mem_rdata_i
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD,
      S_WR,
      S_RMW_RD,
      S_RMW_WR,
      S_DONE
   } state_t;

   localparam logic [2:0] LAT = 3'(RD_LAT);

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [15:0]       wdata_q, wdata_d;
   logic              byte_op_q, byte_op_d;
   logic              sext_q, sext_d;
   logic [2:0]        cnt_q, cnt_d;
   logic [15:0]       word_q, word_d;
   logic [15:0]       rdata_q, rdata_d;
   logic              fault_q, fault_d;
   logic              mem_re, mem_we;
   logic [15:0]       mem_wdata;
   logic              accept;
   logic [7:0]        rd_byte;

   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         state_q   <= S_IDLE;
         addr_q    <= '0;
         wdata_q   <= '0;
         byte_op_q <= 1'b0;
         sext_q    <= 1'b0;
         cnt_q     <= '0;
         word_q    <= '0;
         rdata_q   <= '0;
         fault_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         byte_op_q <= byte_op_d;
         sext_q    <= sext_d;
         cnt_q     <= cnt_d;
         word_q    <= word_d;
         rdata_q   <= rdata_d;
         fault_q   <= fault_d;
      end
   end

   // DONE counts as not busy so a new request can be taken with no idle gap.
   assign accept  = ((state_q == S_IDLE) || (state_q == S_DONE)) && (req_rd_i || req_wr_i);
   assign rd_byte = addr_q[0] ? mem_rdata_i[15:8] : mem_rdata_i[7:0];

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      byte_op_d = byte_op_q;
      sext_d    = sext_q;
      cnt_d     = cnt_q;
      word_d    = word_q;
      rdata_d   = rdata_q;
      fault_d   = fault_q;
      mem_re    = 1'b0;
      mem_we    = 1'b0;
      mem_wdata = '0;

      case (state_q)
         S_IDLE, S_DONE: begin
            state_d = S_IDLE;
            fault_d = 1'b0;
            if (accept) begin
               addr_d    = addr_i;
               wdata_d   = wdata_i;
               byte_op_d = byte_op_i;
               sext_d    = sext_i;
               cnt_d     = LAT;
`ifdef MAU_MISALIGN_TRAP_EN
               if (!byte_op_i && addr_i[0]) begin
                  state_d = S_DONE;
                  fault_d = 1'b1;
               end else
`endif
               if (req_wr_i) begin
                  state_d = byte_op_i ? S_RMW_RD : S_WR;
               end else begin
                  state_d = S_RD;
               end
            end
         end
         S_RD, S_RMW_RD: begin
            mem_re = (cnt_q == LAT);
            if (cnt_q == 3'd0) begin
               word_d = mem_rdata_i;
               if (state_q == S_RD) begin
                  rdata_d = byte_op_q ? {{8{sext_q & rd_byte[7]}}, rd_byte} : mem_rdata_i;
                  state_d = S_DONE;
               end else begin
                  state_d = S_RMW_WR;
               end
            end else begin
               cnt_d = cnt_q - 3'd1;
            end
         end
         S_WR: begin
            mem_we    = 1'b1;
            mem_wdata = wdata_q;
            state_d   = S_DONE;
         end
         S_RMW_WR: begin
            mem_we    = 1'b1;
            mem_wdata = addr_q[0] ? {wdata_q[7:0], word_q[7:0]} : {word_q[15:8], wdata_q[7:0]};
            state_d   = S_DONE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign rdata_o     = rdata_q;
   assign ready_o     = (state_q == S_DONE);
   assign busy_o      = (state_q != S_IDLE) && (state_q != S_DONE);
   assign mem_addr_o  = addr_q[ADDR_W-1:1];
   assign mem_re_o    = mem_re;
   assign mem_we_o    = mem_we;
   assign mem_wdata_o = mem_wdata;
`ifdef MAU_MISALIGN_TRAP_EN
   assign fault_o     = fault_q;
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - directed self-checking bench for mem_access_unit
// Honours MAU_MISALIGN_TRAP_EN to match the DUT build.
module tb_mem_access_unit;

   localparam int ADDR_W = 16;
   localparam int RD_LAT = 1;

   logic              clk;
   logic              reset_n;
   logic              req_rd, req_wr, byte_op, sext;
   logic [ADDR_W-1:0] addr;
   logic [15:0]       wdata;
   logic [15:0]       rdata;
   logic              ready, busy;
`ifdef MAU_MISALIGN_TRAP_EN
   logic              fault;
`endif
   logic [ADDR_W-2:0] mem_addr;
   logic              mem_re, mem_we;
   logic [15:0]       mem_wdata;
   logic [15:0]       mem_rdata;

   logic [15:0]       mem [0:255];

   int checks = 0;
   int errors = 0;

   mem_access_unit #(.ADDR_W(ADDR_W), .RD_LAT(RD_LAT)) dut (
      .clk_i       (clk),
      .reset_i     (reset_n),
      .req_rd_i    (req_rd),
      .req_wr_i    (req_wr),
      .byte_op_i   (byte_op),
      .sext_i      (sext),
      .addr_i      (addr),
      .wdata_i     (wdata),
      .rdata_o     (rdata),
      .ready_o     (ready),
      .busy_o      (busy),
`ifdef MAU_MISALIGN_TRAP_EN
      .fault_o     (fault),
`endif
      .mem_addr_o  (mem_addr),
      .mem_re_o    (mem_re),
      .mem_we_o    (mem_we),
      .mem_wdata_o (mem_wdata),
      .mem_rdata_i (mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Synchronous memory with one cycle of read latency.
   always @(posedge clk) begin
      if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
      if (mem_re) mem_rdata <= mem[mem_addr[7:0]];
   end

   initial begin
      #100000;
      $display("FAIL watchdog: observed no finish, expected finish before time limit");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic clear_inputs();
      req_rd  = 1'b0;
      req_wr  = 1'b0;
      byte_op = 1'b0;
      sext    = 1'b0;
      addr    = '0;
      wdata   = '0;
   endtask

   // Call just after a negedge; returns at the negedge inside cycle 1.
   task automatic req(input logic rd, input logic wr, input logic bop, input logic sx,
                      input logic [15:0] a, input logic [15:0] wd);
      req_rd  = rd;
      req_wr  = wr;
      byte_op = bop;
      sext    = sx;
      addr    = a;
      wdata   = wd;
      @(negedge clk);
      clear_inputs();
   endtask

   task automatic word_store(input logic [15:0] a, input logic [15:0] wd);
      req(1'b0, 1'b1, 1'b0, 1'b0, a, wd);
      repeat (2) @(negedge clk);
   endtask

   task automatic byte_load(input string tag, input logic [15:0] a, input logic sx,
                            input logic [15:0] exp);
      req(1'b1, 1'b0, 1'b1, sx, a, 16'h0);
      repeat (2) @(negedge clk);
      chk({tag, "_ready"}, 32'(ready), 1);
      chk({tag, "_rdata"}, 32'(rdata), 32'(exp));
   endtask

   task automatic wait_ready(input string tag, input int max_cycles);
      int n = 0;
      while (ready !== 1'b1 && n < max_cycles) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_ready_seen"}, 32'(ready), 1);
   endtask

   initial begin
      clear_inputs();
      reset_n = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_rdata", 32'(rdata), 0);
      chk("rst_ready", 32'(ready), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_mem_re", 32'(mem_re), 0);
      chk("rst_mem_we", 32'(mem_we), 0);
      chk("rst_mem_wdata", 32'(mem_wdata), 0);
      chk("rst_mem_addr", 32'(mem_addr), 0);
`ifdef MAU_MISALIGN_TRAP_EN
      chk("rst_fault", 32'(fault), 0);
`endif
      reset_n = 1'b1;
      @(negedge clk);

      // Word store then back-to-back word load.
      req(1'b0, 1'b1, 1'b0, 1'b0, 16'h0010, 16'hBEEF);
      chk("ws_we", 32'(mem_we), 1);
      chk("ws_re", 32'(mem_re), 0);
      chk("ws_addr", 32'(mem_addr), 'h0008);
      chk("ws_wdata", 32'(mem_wdata), 'hBEEF);
      chk("ws_busy", 32'(busy), 1);
      @(negedge clk);
      chk("ws_ready", 32'(ready), 1);
      chk("ws_we_c2", 32'(mem_we), 0);
      req(1'b1, 1'b0, 1'b0, 1'b0, 16'h0010, 16'h0);
      chk("wl_re_c1", 32'(mem_re), 1);
      chk("wl_addr_c1", 32'(mem_addr), 'h0008);
      chk("wl_ready_c1", 32'(ready), 0);
      @(negedge clk);
      chk("wl_re_c2", 32'(mem_re), 0);
      chk("wl_ready_c2", 32'(ready), 0);
      chk("wl_busy_c2", 32'(busy), 1);
      @(negedge clk);
      chk("wl_ready_c3", 32'(ready), 1);
      chk("wl_rdata", 32'(rdata), 'hBEEF);
      @(negedge clk);
      chk("wl_ready_c4", 32'(ready), 0);
      chk("wl_busy_c4", 32'(busy), 0);

      // Byte store read-modify-write, with an ignored request while busy.
      word_store(16'h0020, 16'h1234);
      req(1'b0, 1'b1, 1'b1, 1'b0, 16'h0021, 16'h00AB);
      chk("bs_re_c1", 32'(mem_re), 1);
      chk("bs_we_c1", 32'(mem_we), 0);
      chk("bs_addr_c1", 32'(mem_addr), 'h0010);
      @(negedge clk);
      chk("bs_re_c2", 32'(mem_re), 0);
      chk("bs_we_c2", 32'(mem_we), 0);
      req_wr = 1'b1;
      addr   = 16'h0060;
      wdata  = 16'hDEAD;
      @(negedge clk);
      clear_inputs();
      chk("bs_we_c3", 32'(mem_we), 1);
      chk("bs_wdata_c3", 32'(mem_wdata), 'hAB34);
      chk("bs_addr_c3", 32'(mem_addr), 'h0010);
      @(negedge clk);
      chk("bs_ready_c4", 32'(ready), 1);
      @(negedge clk);
      chk("ign_we", 32'(mem_we), 0);
      chk("ign_busy", 32'(busy), 0);
      chk("bs_mem", 32'(mem[8'h10]), 'hAB34);
      chk("ign_mem", 32'(mem[8'h30] === 16'hDEAD), 0);

      // Byte loads with sign/zero extension from both byte lanes.
      word_store(16'h0030, 16'h80F0);
      byte_load("bl_lo_sx", 16'h0030, 1'b1, 16'hFFF0);
      byte_load("bl_hi_zx", 16'h0031, 1'b0, 16'h0080);
      byte_load("bl_hi_sx", 16'h0031, 1'b1, 16'hFF80);
      byte_load("bl_lo_zx", 16'h0030, 1'b0, 16'h00F0);
      @(negedge clk);

      // Simultaneous read and write: write wins.
      req(1'b1, 1'b1, 1'b0, 1'b0, 16'h0040, 16'h5A5A);
      chk("rw_we_c1", 32'(mem_we), 1);
      chk("rw_re_c1", 32'(mem_re), 0);
      @(negedge clk);
      chk("rw_ready_c2", 32'(ready), 1);
      chk("rw_re_c2", 32'(mem_re), 0);
      chk("rw_rdata_held", 32'(rdata), 'h00F0);
      @(negedge clk);
      chk("rw_re_c3", 32'(mem_re), 0);
      chk("rw_mem", 32'(mem[8'h20]), 'h5A5A);

      // Asynchronous reset during RMW_RD aborts the byte store.
      req(1'b0, 1'b1, 1'b1, 1'b0, 16'h0020, 16'h00CD);
      chk("ab_re_c1", 32'(mem_re), 1);
      #2 reset_n = 1'b0;
      #1;
      chk("ab_busy", 32'(busy), 0);
      chk("ab_re", 32'(mem_re), 0);
      chk("ab_we", 32'(mem_we), 0);
      chk("ab_addr", 32'(mem_addr), 0);
      chk("ab_rdata", 32'(rdata), 0);
      chk("ab_ready", 32'(ready), 0);
      chk("ab_wdata", 32'(mem_wdata), 0);
      @(negedge clk);
      reset_n = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk("ab_no_ready", 32'(ready), 0);
      end
      chk("ab_mem", 32'(mem[8'h10]), 'hAB34);
      req(1'b1, 1'b0, 1'b0, 1'b0, 16'h0020, 16'h0);
      wait_ready("ab_reload", 8);
      chk("ab_reload_rdata", 32'(rdata), 'hAB34);
      @(negedge clk);

      // Misaligned word load at 0x0003.
      word_store(16'h0002, 16'h7E81);
      req(1'b1, 1'b0, 1'b0, 1'b0, 16'h0003, 16'h0);
`ifdef MAU_MISALIGN_TRAP_EN
      chk("mis_ready_c1", 32'(ready), 1);
      chk("mis_fault_c1", 32'(fault), 1);
      chk("mis_re_c1", 32'(mem_re), 0);
      chk("mis_rdata", 32'(rdata), 'hAB34);
      @(negedge clk);
      chk("mis_fault_c2", 32'(fault), 0);
      chk("mis_ready_c2", 32'(ready), 0);
      chk("mis_re_c2", 32'(mem_re), 0);
`else
      chk("mis_re_c1", 32'(mem_re), 1);
      chk("mis_addr_c1", 32'(mem_addr), 'h0001);
      repeat (2) @(negedge clk);
      chk("mis_ready_c3", 32'(ready), 1);
      chk("mis_rdata", 32'(rdata), 'h7E81);
`endif
      @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
